// File: rtl/pinjie_split.sv
// pinjie_split: splits a side-by-side stitched stream (left half, then right
// half of each line) into left/right pixel pairs. The left half of a line is
// parked in a line buffer; each right pixel is paired with the left pixel at
// the same index and emitted two clocks after the right pixel is accepted.
module pinjie_split #(
  parameter int IW = 1280,
  parameter int IH = 480,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vs,
  input  logic          in_de,
  input  logic [DW-1:0] in_data,
  output logic          out_vs,
  output logic          out_de,
  output logic [DW-1:0] out_data0,
  output logic [DW-1:0] out_data1,
  output logic          line_err
);

  localparam int HW = IW / 2;
  localparam int XW = (HW > 1) ? $clog2(HW) : 1;
  localparam int LW = $clog2(IH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEFT,
    S_RIGHT,
    S_DROP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_vs_d1;
  logic            r_vs_d2;
  logic            r_armed;
  logic            w_vs_rise;

  logic [XW-1:0]   r_x;
  logic [XW-1:0]   w_x_nxt;
  logic            w_x_last;
  logic [LW-1:0]   r_line;
  logic [LW-1:0]   w_line_nxt;

  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_err_set;
  logic            r_line_err;

  logic [DW-1:0]   r_mem [HW];
  logic [DW-1:0]   r_rd_data;

  logic            r_p1_vld;
  logic [DW-1:0]   r_p1_right;
  logic            r_out_de;
  logic [DW-1:0]   r_out_data0;
  logic [DW-1:0]   r_out_data1;

  assign w_vs_rise = in_vs & ~r_vs_d1;
  assign w_x_last  = (r_x == XW'(HW - 1));

  // Frame-sync edge detect, 2-clk out_vs delay, and arming after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_d1 <= 1'b0;
      r_vs_d2 <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_vs_d1 <= in_vs;
      r_vs_d2 <= r_vs_d1;
      if (w_vs_rise) begin
        r_armed <= 1'b1;
      end
    end
  end

  // State, pixel/line counters and sticky error register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_line     <= '0;
      r_line_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_line  <= w_line_nxt;
      if (w_vs_rise) begin
        r_line_err <= 1'b0;
      end else if (w_err_set) begin
        r_line_err <= 1'b1;
      end
    end
  end

  // Next-state, counter advance and buffer strobes; a frame start overrides all
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_line_nxt  = r_line;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_err_set   = 1'b0;
    if (w_vs_rise) begin
      w_state_nxt = S_IDLE;
      w_x_nxt     = '0;
      w_line_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_de && r_armed) begin
            if (r_line >= LW'(IH)) begin
              w_state_nxt = S_DROP;
              w_err_set   = 1'b1;
            end else begin
              // r_x is 0 here, so this pixel lands at left index 0
              w_wr_en     = 1'b1;
              w_state_nxt = w_x_last ? S_RIGHT : S_LEFT;
              w_x_nxt     = w_x_last ? '0 : r_x + XW'(1);
            end
          end
        end
        S_LEFT: begin
          if (in_de) begin
            w_wr_en = 1'b1;
            if (w_x_last) begin
              w_state_nxt = S_RIGHT;
              w_x_nxt     = '0;
            end else begin
              w_x_nxt = r_x + XW'(1);
            end
          end
        end
        S_RIGHT: begin
          if (in_de) begin
            w_rd_en = 1'b1;
            if (w_x_last) begin
              w_state_nxt = S_IDLE;
              w_x_nxt     = '0;
              w_line_nxt  = r_line + LW'(1);
            end else begin
              w_x_nxt = r_x + XW'(1);
            end
          end
        end
        S_DROP: begin
          w_state_nxt = S_DROP;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Line buffer: left-half write, right-half synchronous read at the same index
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_x] <= in_data;
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[r_x];
    end
  end

  // Two-stage pair pipeline; not flushed by frame start so in-flight pairs complete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_vld    <= 1'b0;
      r_p1_right  <= '0;
      r_out_de    <= 1'b0;
      r_out_data0 <= '0;
      r_out_data1 <= '0;
    end else begin
      r_p1_vld <= w_rd_en;
      if (w_rd_en) begin
        r_p1_right <= in_data;
      end
      r_out_de <= r_p1_vld;
      if (r_p1_vld) begin
        r_out_data0 <= r_rd_data;
        r_out_data1 <= r_p1_right;
      end
    end
  end

  assign out_vs    = r_vs_d2;
  assign out_de    = r_out_de;
  assign out_data0 = r_out_data0;
  assign out_data1 = r_out_data1;
  assign line_err  = r_line_err;

endmodule

// File: doc/pinjie_split.md
PINJIE_SPLIT -- requirements
Module: pinjie_split

Interface
REQ-001 The block SHALL have parameter IW, default 1280, meaning stitched input line width in pixels (even).
REQ-002 The block SHALL have parameter IH, default 480, meaning stitched input lines per frame.
REQ-003 The block SHALL have parameter DW, default 16, meaning pixel width (RGB565).
REQ-004 The block SHALL have port clk  input  1  pixel clock; the single clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port in_vs  input  1  frame sync of the stitched stream; a rising edge marks frame start.
REQ-007 The block SHALL have port in_de  input  1  pixel valid of the stitched stream.
REQ-008 The block SHALL have port in_data  input  DW  stitched pixel; left image first, then right image, per line.
REQ-009 The block SHALL have port out_vs  output  1  in_vs delayed by exactly 2 clk.
REQ-010 The block SHALL have port out_de  output  1  pixel-pair valid.
REQ-011 The block SHALL have port out_data0  output  DW  left-image pixel of the pair.
REQ-012 The block SHALL have port out_data1  output  DW  right-image pixel of the pair.
REQ-013 The block SHALL have port line_err  output  1  sticky malformed-line flag, cleared at each frame start.

Function
REQ-014 The block SHALL hold a line buffer of IW/2 x DW words, single write port and synchronous single read port.
REQ-015 The block SHALL run an FSM: IDLE, LEFT, RIGHT, DROP.
REQ-016 In IDLE, on the first in_de=1 after a frame start, the FSM SHALL enter LEFT and treat that pixel as left index 0.
REQ-017 In LEFT, each in_de=1 pixel SHALL be written at address x (0..IW/2-1); after index IW/2-1 the FSM SHALL enter RIGHT.
REQ-018 In RIGHT, right pixel index k SHALL be paired with buffered left pixel k; out_de=1 with {out_data0,out_data1} SHALL appear exactly 2 clk after the right pixel is accepted.
REQ-019 The read address SHALL be issued early enough that back-to-back right pixels produce back-to-back out_de cycles with no bubbles.
REQ-020 After right index IW/2-1 the FSM SHALL return to IDLE and increment the line counter (0..IH-1).
REQ-021 in_de gaps (in_de=0) inside LEFT or RIGHT SHALL stall the pixel counter; they SHALL NOT end the line; the line ends only by count.
REQ-022 A rising edge of in_vs in any state SHALL reset the FSM to IDLE, the pixel and line counters to 0, and line_err to 0; the pixel in the same cycle SHALL be ignored.
REQ-023 If in_de=1 arrives after the line counter has reached IH, the FSM SHALL enter DROP, discard pixels until the next in_vs rising edge, and set line_err.
REQ-024 out_de SHALL be 0 in all cycles not covered by REQ-018; out_data0/out_data1 SHALL hold their last values when out_de=0.
REQ-025 An in_vs rising edge during RIGHT SHALL NOT suppress pairs already in the 2-stage output pipeline; those pairs SHALL still be emitted.
REQ-026 All datapath registers SHALL be DW bits, with no truncation or reordering of bits.

Reset
REQ-027 While rst=1, out_vs, out_de and line_err SHALL be 0, out_data0/out_data1 SHALL be 0, the FSM SHALL be IDLE and the counters SHALL be 0.
REQ-028 Line-buffer contents SHALL NOT be reset.
REQ-029 After rst deasserts, the first in_de=1 pixel SHALL NOT be processed until an in_vs rising edge has been seen.

Verification
REQ-030 Full frame: IW=8, IH=2, contiguous pixels 0..7 per line -> per line, out_de high 4 consecutive cycles with pairs (0,4),(1,5),(2,6),(3,7); first pair 2 clk after pixel 4 is accepted.
REQ-031 Gapped input: in_de toggling 1/0 across a line -> the same pairs as REQ-030, with out_de pulses spaced like the right-half input and each pulse 2 clk after its right pixel.
REQ-032 Mid-line vs: in_vs rises after left pixel 2 -> the next line restarts at left index 0; no pair uses stale data; line_err=0.
REQ-033 Overlong frame: a third line sent with IH=2 -> no out_de for it, and line_err=1 until the next in_vs rising edge.
REQ-034 Reset mid-RIGHT: rst pulsed during RIGHT -> all outputs 0 immediately, pipeline flushed, and no output until an in_vs edge followed by a full line.
